shift_register_deserializer_async: RTL

//  Serial-in/parallel-out receiver: the capture end of the team's parallel-load MSB-first

---
 rtl/shift_register_deserializer_async.sv | 101 ++++++++++
 1 files changed

// File: rtl/shift_register_deserializer_async.sv
// Serial-in/parallel-out receiver for the MSB-first shift-register link.
// Rebuilds WIDTH-bit words and hands them off with a valid/ack handshake; flags dropped words.
module shift_register_deserializer_async #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_en,
  input  logic             serial_in,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             valid_reg;
  logic             overrun_reg;

  logic             shift_now;
  logic             completion;
  logic [WIDTH-1:0] word_next;

  // abort takes priority over a bit strobe arriving in the same cycle
  assign shift_now  = (state_reg == ST_SHIFT) && !abort && bit_en;
  assign completion = shift_now && (count_reg == LAST_BIT);
  assign word_next  = {shreg_reg[WIDTH-2:0], serial_in};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      shreg_reg <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SHIFT;
            count_reg <= '0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
          end else if (bit_en) begin
            shreg_reg <= word_next;
            if (count_reg == LAST_BIT) begin
              state_reg <= ST_IDLE;
              count_reg <= '0;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  // A completing word is only lost when the previous one is still unacknowledged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (completion) begin
        if (!valid_reg || data_ack) begin
          data_out_reg <= word_next;
          valid_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (data_ack) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = valid_reg;
  assign busy       = (state_reg == ST_SHIFT);
  assign overrun    = overrun_reg;

endmodule
